cpu_trig_gen: RTL and testbench
===============================

# cpu_trig_gen

Parametrised CPU trigger generator: converts a CPU-written trigger request into a qualified trigger output for the acquisition and playback logic. It keeps the legacy level-follow behaviour and adds input synchronisation, write-finished gating, single-pulse and burst modes, overlap detection and an issued-trigger counter. The block sits between the CPU register bank and the trigger fan-out, replacing the single-mode level follower.

## Interface
- CNT_W, 16, width of pulse_len, period and burst_cnt (4..32)
- SYNC_STAGES, 2, synchroniser flops on CPU_trig and write_finished (0..3; 0 = no synchronisation)
- GATE_WR, 1, 1 = a trigger is accepted only while write_finished is high; 0 = write_finished ignored

- clk  in  1  system clock; everything is synchronous to its rising edge
- rst  in  1  synchronous, active-high reset
- mode  in  2  0 = level, 1 = single pulse, 2 = burst, 3 = treated as level
- pulse_len  in  CNT_W  high time per pulse, in cycles; 0 is treated as 1
- period  in  CNT_W  start-to-start pulse spacing in burst mode; values below pulse_len+1 are clamped to pulse_len+1
- burst_cnt  in  CNT_W  pulses per burst; 0 is treated as 1
- write_finished  in  1  qualifier from the write path
- CPU_trig  in  1  trigger request level from the CPU register
- cpu_flag  out  1  registered trigger output
- busy  out  1  high while a pulse or burst is in progress; equals cpu_flag in level mode
- missed  out  1  one-cycle strobe when a request edge is rejected
- trig_count  out  32  count of accepted triggers; wraps from 2^32-1 to 0

## Operation
- Reset: cpu_flag=0, busy=0, missed=0, trig_count=0, FSM in IDLE, synchroniser and edge register at 0. A reset asserted mid-pulse or mid-burst aborts it and takes effect at the next edge.
- Synchronisation: trq and wfq are the synchronised CPU_trig and write_finished. Edge detect is rise = trq & ~trq_d, where trq_d is a register.
- Qualifier: ok = wfq when GATE_WR=1, otherwise 1.
- Config latch: mode, pulse_len, period and burst_cnt are latched on the cycle a trigger is accepted. Input changes while busy have no effect until the block returns to IDLE.
- FSM states:
  - IDLE: in level mode, if trq & ok, go to LEVEL with cpu_flag<=1. In pulse or burst mode, if rise & ok, go to HIGH with cpu_flag<=1 and load the counters. If rise & ~ok, pulse missed.
  - LEVEL: when ~trq or ~ok, go to IDLE with cpu_flag<=0.
  - HIGH: cpu_flag stays 1 for pulse_len cycles. Then, if pulses remain, go to LOW. Otherwise go to IDLE.
  - LOW: cpu_flag=0 until period cycles have elapsed since the current pulse started, then go to HIGH and decrement the remaining-pulse count.
- Overlap: a rise while in HIGH or LOW is rejected, pulses missed for one cycle, and does not extend or restart the pulse train.
- busy = (state != IDLE).
- trig_count increments by 1 on each IDLE->HIGH or IDLE->LEVEL transition. Individual burst pulses do not increment it.
- A CPU_trig held high across reset release produces one accepted edge (pulse/burst modes) or the flag (level mode) after synchroniser latency.

## Timing
- Latency: cpu_flag rises at the (SYNC_STAGES+1)-th rising edge at which CPU_trig is sampled high, counting that first edge as 1. With SYNC_STAGES=0, the flag rises on the first edge after CPU_trig rises.
- Level mode: cpu_flag falls with the same latency after CPU_trig or write_finished falls.
- Single pulse: cpu_flag is high for exactly max(pulse_len,1) consecutive cycles.
- Burst: pulse k starts exactly k*period_eff cycles after pulse 0, where period_eff = max(period, pulse_len_eff+1). There is at least one low cycle between pulses.
- busy rises in the same cycle as the first cpu_flag and falls in the same cycle as the last cpu_flag.
- missed is high for exactly one cycle per rejected edge, aligned to the cycle the rejected edge is evaluated.
- trig_count updates in the same cycle cpu_flag first rises.
- A new edge is accepted in the first cycle the FSM is back in IDLE.

## Test plan
- Level mode, SYNC_STAGES=2, GATE_WR=1, write_finished=1: CPU_trig high for 10 cycles -> cpu_flag high 10 cycles, starting at the 3rd sampling edge; trig_count=1.
- Single mode, pulse_len=5: CPU_trig rising edge -> exactly 5 cycles of cpu_flag and busy. A second edge 2 cycles into the pulse -> missed=1 for one cycle, pulse length unchanged. pulse_len=0 -> 1-cycle pulse.
- Burst mode, pulse_len=3, period=8, burst_cnt=4 -> 4 pulses starting at offsets 0, 8, 16, 24; trig_count +1. With period=2, spacing is clamped to 4.
- Gating: write_finished=0 with CPU_trig edge in single mode -> no cpu_flag, missed=1. With GATE_WR=0 the same stimulus -> pulse issued.
- Reset mid-burst (rst high during the 2nd pulse) -> cpu_flag, busy and trig_count all 0 at the next edge; the FSM restarts cleanly on the next edge after rst is released.
- Wrap: force trig_count to 2^32-1, accept one trigger -> trig_count=0.

Source files
------------

// File: rtl/cpu_trig_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : cpu_trig_gen_if
// Description : Bundles the CPU-side configuration and request signals and the
//               trigger outputs of cpu_trig_gen.
//               master : CPU register bank side. It drives mode, pulse_len,
//                        period, burst_cnt, write_finished and CPU_trig.
//               slave  : trigger generator side. It drives cpu_flag, busy,
//                        missed and trig_count.
// Revision    : 1.0 - initial release
// ============================================================================
interface cpu_trig_gen_if #(
  parameter int CNT_W = 16
);
  logic [1:0]       mode;
  logic [CNT_W-1:0] pulse_len;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] burst_cnt;
  logic             write_finished;
  logic             CPU_trig;
  logic             cpu_flag;
  logic             busy;
  logic             missed;
  logic [31:0]      trig_count;

  modport master (
    output mode, pulse_len, period, burst_cnt, write_finished, CPU_trig,
    input  cpu_flag, busy, missed, trig_count
  );

  modport slave (
    input  mode, pulse_len, period, burst_cnt, write_finished, CPU_trig,
    output cpu_flag, busy, missed, trig_count
  );
endinterface
`default_nettype wire

// File: rtl/cpu_trig_gen.sv
`default_nettype none
// ============================================================================
// Module      : cpu_trig_gen
// Description : Converts a CPU-written trigger request into a qualified
//               trigger. It supports level-follow, single-pulse and burst
//               modes. It synchronises the request and write-finished inputs,
//               gates triggers on write-finished, flags rejected request
//               edges and counts the triggers it accepts.
// Ports       : clk, rst - clock and synchronous active-high reset
//               bus      - cpu_trig_gen_if.slave (config and request in;
//                          cpu_flag, busy, missed and trig_count out)
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_trig_gen #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter bit GATE_WR     = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  cpu_trig_gen_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LEVEL = 2'd1,
    S_HIGH  = 2'd2,
    S_LOW   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] c_one   = CNT_W'(1);
  localparam logic [CNT_W:0]   c_one_w = (CNT_W+1)'(1);

  logic w_trq;
  logic w_wfq;

  generate
    if (SYNC_STAGES == 0) begin : g_no_sync
      assign w_trq = bus.CPU_trig;
      assign w_wfq = bus.write_finished;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] r_trq_sh;
      logic [SYNC_STAGES-1:0] r_wfq_sh;
      always_ff @(posedge clk) begin
        if (rst) begin
          r_trq_sh <= '0;
          r_wfq_sh <= '0;
        end else begin
          r_trq_sh[0] <= bus.CPU_trig;
          r_wfq_sh[0] <= bus.write_finished;
          for (int i = 1; i < SYNC_STAGES; i++) begin
            r_trq_sh[i] <= r_trq_sh[i-1];
            r_wfq_sh[i] <= r_wfq_sh[i-1];
          end
        end
      end
      assign w_trq = r_trq_sh[SYNC_STAGES-1];
      assign w_wfq = r_wfq_sh[SYNC_STAGES-1];
    end
  endgenerate

  state_t           r_state;
  logic             r_trq_d;
  logic [CNT_W-1:0] r_len;    // latched effective pulse length
  logic [CNT_W:0]   r_per;    // latched effective period (one bit wider: len+1 may overflow CNT_W)
  logic [CNT_W-1:0] r_hcnt;   // high cycles left in the current pulse, minus one
  logic [CNT_W:0]   r_pcnt;   // cycles left until the next pulse start, minus one
  logic [CNT_W-1:0] r_rem;    // pulses still to issue after the current one
  logic             r_flag;
  logic             r_busy;
  logic             r_missed;
  logic [31:0]      r_trig_cnt;

  logic             w_ok;
  logic             w_rise;
  logic             w_is_level;
  logic [CNT_W-1:0] w_len_eff;
  logic [CNT_W-1:0] w_cnt_eff;
  logic [CNT_W:0]   w_per_min;
  logic [CNT_W:0]   w_per_eff;

  assign w_ok       = GATE_WR ? w_wfq : 1'b1;
  assign w_rise     = w_trq & ~r_trq_d;
  assign w_is_level = (bus.mode == 2'd0) || (bus.mode == 2'd3);
  assign w_len_eff  = (bus.pulse_len == '0) ? c_one : bus.pulse_len;
  assign w_cnt_eff  = (bus.burst_cnt == '0) ? c_one : bus.burst_cnt;
  assign w_per_min  = {1'b0, w_len_eff} + c_one_w;
  assign w_per_eff  = ({1'b0, bus.period} < w_per_min) ? w_per_min : {1'b0, bus.period};

  state_t           w_state_nx;
  logic [CNT_W-1:0] w_len_nx;
  logic [CNT_W:0]   w_per_nx;
  logic [CNT_W-1:0] w_hcnt_nx;
  logic [CNT_W:0]   w_pcnt_nx;
  logic [CNT_W-1:0] w_rem_nx;
  logic             w_accept;
  logic             w_reject;

  always_comb begin
    w_state_nx = r_state;
    w_len_nx   = r_len;
    w_per_nx   = r_per;
    w_hcnt_nx  = r_hcnt;
    w_pcnt_nx  = r_pcnt;
    w_rem_nx   = r_rem;
    w_accept   = 1'b0;
    w_reject   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_is_level) begin
          if (w_trq && w_ok) begin
            w_state_nx = S_LEVEL;
            w_accept   = 1'b1;
          end
        end else if (w_rise) begin
          if (w_ok) begin
            // The configuration is captured here and then held for the
            // whole pulse train.
            w_state_nx = S_HIGH;
            w_accept   = 1'b1;
            w_len_nx   = w_len_eff;
            w_per_nx   = w_per_eff;
            w_hcnt_nx  = w_len_eff - c_one;
            w_pcnt_nx  = w_per_eff - c_one_w;
            w_rem_nx   = (bus.mode == 2'd2) ? (w_cnt_eff - c_one) : '0;
          end else begin
            w_reject = 1'b1;
          end
        end
      end
      S_LEVEL: begin
        if (!w_trq || !w_ok) begin
          w_state_nx = S_IDLE;
        end
      end
      S_HIGH: begin
        w_reject  = w_rise;
        // The period counter keeps running through the high phase, so that
        // pulse starts are spaced from start to start.
        w_pcnt_nx = r_pcnt - c_one_w;
        if (r_hcnt == '0) begin
          w_state_nx = (r_rem != '0) ? S_LOW : S_IDLE;
        end else begin
          w_hcnt_nx = r_hcnt - c_one;
        end
      end
      S_LOW: begin
        w_reject = w_rise;
        if (r_pcnt == '0) begin
          w_state_nx = S_HIGH;
          w_rem_nx   = r_rem - c_one;
          w_hcnt_nx  = r_len - c_one;
          w_pcnt_nx  = r_per - c_one_w;
        end else begin
          w_pcnt_nx = r_pcnt - c_one_w;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_trq_d    <= 1'b0;
      r_len      <= '0;
      r_per      <= '0;
      r_hcnt     <= '0;
      r_pcnt     <= '0;
      r_rem      <= '0;
      r_flag     <= 1'b0;
      r_busy     <= 1'b0;
      r_missed   <= 1'b0;
      r_trig_cnt <= '0;
    end else begin
      r_state  <= w_state_nx;
      r_trq_d  <= w_trq;
      r_len    <= w_len_nx;
      r_per    <= w_per_nx;
      r_hcnt   <= w_hcnt_nx;
      r_pcnt   <= w_pcnt_nx;
      r_rem    <= w_rem_nx;
      // The outputs are registered from the next state. They change together
      // with the state register and are free of glitches.
      r_flag   <= (w_state_nx == S_HIGH) || (w_state_nx == S_LEVEL);
      r_busy   <= (w_state_nx != S_IDLE);
      r_missed <= w_reject;
      if (w_accept) begin
        r_trig_cnt <= r_trig_cnt + 32'd1;
      end
    end
  end

  assign bus.cpu_flag   = r_flag;
  assign bus.busy       = r_busy;
  assign bus.missed     = r_missed;
  assign bus.trig_count = r_trig_cnt;

endmodule
`default_nettype wire

// File: tb/tb_cpu_trig_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_trig_gen
// Description : Self-checking bench for cpu_trig_gen. It runs two instances:
//               dut    (SYNC_STAGES=2, GATE_WR=1)
//               dut_ng (SYNC_STAGES=0, GATE_WR=0)
//               Both instances share the stimulus. Expected waveforms come
//               from a behavioural model of pulse trains.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_trig_gen;
  localparam int CNT_W = 16;
  localparam int N     = 128;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]       mode;
  logic [CNT_W-1:0] pulse_len, period, burst_cnt;
  logic             wf, trig;

  cpu_trig_gen_if #(.CNT_W(CNT_W)) bus0 ();
  cpu_trig_gen_if #(.CNT_W(CNT_W)) bus1 ();

  assign bus0.mode = mode;  assign bus0.pulse_len = pulse_len;  assign bus0.period = period;
  assign bus0.burst_cnt = burst_cnt;  assign bus0.write_finished = wf;  assign bus0.CPU_trig = trig;
  assign bus1.mode = mode;  assign bus1.pulse_len = pulse_len;  assign bus1.period = period;
  assign bus1.burst_cnt = burst_cnt;  assign bus1.write_finished = wf;  assign bus1.CPU_trig = trig;

  cpu_trig_gen #(.CNT_W(CNT_W), .SYNC_STAGES(2), .GATE_WR(1'b1)) dut (
    .clk(clk), .rst(rst), .bus(bus0.slave));
  cpu_trig_gen #(.CNT_W(CNT_W), .SYNC_STAGES(0), .GATE_WR(1'b0)) dut_ng (
    .clk(clk), .rst(rst), .bus(bus1.slave));

  int sync_of [0:1] = '{2, 0};
  bit gate_of [0:1] = '{1'b1, 1'b0};

  int n_tests = 0;
  int n_fail  = 0;

  bit          wave  [0:N-1];
  logic        cap_f [0:1][0:N-1];
  logic        cap_b [0:1][0:N-1];
  logic        cap_m [0:1][0:N-1];
  logic [31:0] cap_c [0:1][0:N-1];
  logic        exp_f [0:1][0:N-1];
  logic        exp_b [0:1][0:N-1];
  logic        exp_m [0:1][0:N-1];
  logic [31:0] exp_c [0:1][0:N-1];
  logic [31:0] cnt_model [0:1];

  task automatic clear_wave();
    for (int i = 0; i < N; i++) wave[i] = 1'b0;
  endtask

  // Reference model: expected output sequences from the request waveform and
  // the current configuration. A request is assumed low before wave[0].
  task automatic build_model(input int n);
    int len_e, per_e, b_e, dur, busy_until, s, idx;
    bit ok, prev, lvl;
    logic [31:0] c;
    lvl   = (mode == 2'd0) || (mode == 2'd3);
    len_e = (pulse_len == '0) ? 1 : int'(pulse_len);
    per_e = (int'(period) < len_e + 1) ? len_e + 1 : int'(period);
    b_e   = (mode == 2'd2) ? ((burst_cnt == '0) ? 1 : int'(burst_cnt)) : 1;
    dur   = (b_e - 1) * per_e + len_e;
    for (int d = 0; d < 2; d++) begin
      s = sync_of[d];
      ok = !gate_of[d] || wf;
      c = cnt_model[d];
      busy_until = 0;
      for (int i = 0; i < N; i++) begin
        exp_f[d][i] = 1'b0; exp_b[d][i] = 1'b0; exp_m[d][i] = 1'b0; exp_c[d][i] = c;
      end
      for (int w = 0; w < n; w++) begin
        prev = (w == 0) ? 1'b0 : wave[w-1];
        if (lvl) begin
          if (wave[w] && ok) begin
            if (!prev) c = c + 32'd1;
            if (w + s < n) begin exp_f[d][w+s] = 1'b1; exp_b[d][w+s] = 1'b1; end
          end
        end else if (wave[w] && !prev) begin
          // An edge is accepted only once the previous train is over and the
          // block has spent one cycle idle.
          if (w >= busy_until && ok) begin
            c = c + 32'd1;
            for (int k = 0; k < b_e; k++)
              for (int t = 0; t < len_e; t++) begin
                idx = w + s + k * per_e + t;
                if (idx < n) exp_f[d][idx] = 1'b1;
              end
            for (int t = 0; t < dur; t++)
              if (w + s + t < n) exp_b[d][w+s+t] = 1'b1;
            busy_until = w + dur + 1;
          end else if (w + s < n) begin
            exp_m[d][w+s] = 1'b1;
          end
        end
        if (w + s < n) exp_c[d][w+s] = c;
      end
      cnt_model[d] = c;
    end
  endtask

  // Plays wave[0..n-1] on CPU_trig and records both DUTs after every edge.
  // With scramble set, the configuration inputs are randomised partway
  // through, after both DUTs have captured it.
  task automatic capture(input int n, input bit scramble);
    for (int i = 0; i < n; i++) begin
      trig = wave[i];
      if (scramble && i == 3) begin
        mode      = 2'($urandom_range(3, 0));
        pulse_len = CNT_W'($urandom);
        period    = CNT_W'($urandom);
        burst_cnt = CNT_W'($urandom);
      end
      @(negedge clk);
      cap_f[0][i] = bus0.cpu_flag; cap_b[0][i] = bus0.busy;
      cap_m[0][i] = bus0.missed;   cap_c[0][i] = bus0.trig_count;
      cap_f[1][i] = bus1.cpu_flag; cap_b[1][i] = bus1.busy;
      cap_m[1][i] = bus1.missed;   cap_c[1][i] = bus1.trig_count;
    end
    trig = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    mode = 2'd1; pulse_len = 16'd2; period = '0; burst_cnt = '0; wf = 1'b1; trig = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({bus0.cpu_flag, bus0.busy, bus0.missed, bus0.trig_count,
         bus1.cpu_flag, bus1.busy, bus1.missed, bus1.trig_count} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: dut f/b/m/cnt=%b%b%b %0d dut_ng=%b%b%b %0d want all 0",
               bus0.cpu_flag, bus0.busy, bus0.missed, bus0.trig_count,
               bus1.cpu_flag, bus1.busy, bus1.missed, bus1.trig_count);
    end
    // CPU_trig is held high across the release of reset. This must give
    // exactly one pulse.
    rst = 1'b0;
    cnt_model[0] = '0; cnt_model[1] = '0;
    clear_wave();
    for (int i = 0; i < 10; i++) wave[i] = 1'b1;
    build_model(12);
    capture(12, 1'b0);
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 12; i++) begin
        n_tests++;
        if ({cap_f[d][i], cap_b[d][i], cap_m[d][i], cap_c[d][i]} !==
            {exp_f[d][i], exp_b[d][i], exp_m[d][i], exp_c[d][i]}) begin
          n_fail++;
          $display("FAIL reset_release dut%0d cyc%0d f/b/m/cnt got %b%b%b %0d want %b%b%b %0d", d, i,
                   cap_f[d][i], cap_b[d][i], cap_m[d][i], cap_c[d][i], exp_f[d][i], exp_b[d][i], exp_m[d][i], exp_c[d][i]);
        end
      end
  endtask

  task automatic test_level();
    for (int sc = 0; sc < 2; sc++) begin
      mode = (sc == 0) ? 2'd0 : 2'd3;
      clear_wave();
      if (sc == 0) for (int i = 0; i < 10; i++) wave[i] = 1'b1;
      else begin wave[0] = 1'b1; wave[1] = 1'b1; wave[3] = 1'b1; wave[4] = 1'b1; wave[5] = 1'b1; end
      build_model(16);
      capture(16, 1'b0);
      for (int d = 0; d < 2; d++)
        for (int i = 0; i < 16; i++) begin
          n_tests++;
          if ({cap_f[d][i], cap_b[d][i], cap_m[d][i], cap_c[d][i]} !==
              {exp_f[d][i], exp_b[d][i], exp_m[d][i], exp_c[d][i]}) begin
            n_fail++;
            $display("FAIL level sc%0d dut%0d cyc%0d f/b/m/cnt got %b%b%b %0d want %b%b%b %0d", sc, d, i,
                     cap_f[d][i], cap_b[d][i], cap_m[d][i], cap_c[d][i], exp_f[d][i], exp_b[d][i], exp_m[d][i], exp_c[d][i]);
          end
        end
    end
  endtask

  // Scenarios: a 5-cycle pulse; a second edge 2 cycles into the pulse; a
  // zero pulse length.
  task automatic test_single();
    for (int sc = 0; sc < 3; sc++) begin
      mode = 2'd1;
      pulse_len = (sc == 2) ? 16'd0 : 16'd5;
      clear_wave();
      wave[0] = 1'b1; wave[1] = 1'b1;
      if (sc == 1) begin wave[1] = 1'b0; wave[2] = 1'b1; wave[3] = 1'b1; end
      build_model(12);
      capture(12, 1'b0);
      for (int d = 0; d < 2; d++)
        for (int i = 0; i < 12; i++) begin
          n_tests++;
          if ({cap_f[d][i], cap_b[d][i], cap_m[d][i], cap_c[d][i]} !==
              {exp_f[d][i], exp_b[d][i], exp_m[d][i], exp_c[d][i]}) begin
            n_fail++;
            $display("FAIL single sc%0d dut%0d cyc%0d f/b/m/cnt got %b%b%b %0d want %b%b%b %0d", sc, d, i,
                     cap_f[d][i], cap_b[d][i], cap_m[d][i], cap_c[d][i], exp_f[d][i], exp_b[d][i], exp_m[d][i], exp_c[d][i]);
          end
        end
    end
  endtask

  // A second edge in the last pulse cycle is rejected. One cycle later, it
  // is accepted.
  task automatic test_back_to_back();
    for (int sc = 0; sc < 2; sc++) begin
      mode = 2'd1; pulse_len = 16'd3;
      clear_wave();
      wave[0] = 1'b1;
      wave[3 + sc] = 1'b1;
      build_model(14);
      capture(14, 1'b0);
      for (int d = 0; d < 2; d++)
        for (int i = 0; i < 14; i++) begin
          n_tests++;
          if ({cap_f[d][i], cap_b[d][i], cap_m[d][i], cap_c[d][i]} !==
              {exp_f[d][i], exp_b[d][i], exp_m[d][i], exp_c[d][i]}) begin
            n_fail++;
            $display("FAIL back_to_back sc%0d dut%0d cyc%0d f/b/m/cnt got %b%b%b %0d want %b%b%b %0d", sc, d, i,
                     cap_f[d][i], cap_b[d][i], cap_m[d][i], cap_c[d][i], exp_f[d][i], exp_b[d][i], exp_m[d][i], exp_c[d][i]);
          end
        end
    end
  endtask

  task automatic test_burst();
    for (int sc = 0; sc < 2; sc++) begin
      mode = 2'd2; pulse_len = 16'd3; burst_cnt = 16'd4;
      period = (sc == 0) ? 16'd8 : 16'd2;
      clear_wave();
      wave[0] = 1'b1; wave[1] = 1'b1;
      build_model(36);
      capture(36, sc == 0);
      for (int d = 0; d < 2; d++)
        for (int i = 0; i < 36; i++) begin
          n_tests++;
          if ({cap_f[d][i], cap_b[d][i], cap_m[d][i], cap_c[d][i]} !==
              {exp_f[d][i], exp_b[d][i], exp_m[d][i], exp_c[d][i]}) begin
            n_fail++;
            $display("FAIL burst sc%0d dut%0d cyc%0d f/b/m/cnt got %b%b%b %0d want %b%b%b %0d", sc, d, i,
                     cap_f[d][i], cap_b[d][i], cap_m[d][i], cap_c[d][i], exp_f[d][i], exp_b[d][i], exp_m[d][i], exp_c[d][i]);
          end
        end
    end
  endtask

  task automatic test_gating();
    mode = 2'd1; pulse_len = 16'd4; wf = 1'b0;
    repeat (4) @(negedge clk);
    clear_wave();
    wave[0] = 1'b1; wave[1] = 1'b1;
    build_model(10);
    capture(10, 1'b0);
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 10; i++) begin
        n_tests++;
        if ({cap_f[d][i], cap_b[d][i], cap_m[d][i], cap_c[d][i]} !==
            {exp_f[d][i], exp_b[d][i], exp_m[d][i], exp_c[d][i]}) begin
          n_fail++;
          $display("FAIL gating dut%0d cyc%0d f/b/m/cnt got %b%b%b %0d want %b%b%b %0d", d, i,
                   cap_f[d][i], cap_b[d][i], cap_m[d][i], cap_c[d][i], exp_f[d][i], exp_b[d][i], exp_m[d][i], exp_c[d][i]);
        end
      end
    wf = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_mid_burst();
    mode = 2'd2; pulse_len = 16'd3; period = 16'd8; burst_cnt = 16'd4;
    for (int i = 0; i <= 10; i++) begin
      trig = (i < 2);
      @(negedge clk);
    end
    // Both instances are inside their second pulse here.
    n_tests++;
    if ({bus0.cpu_flag, bus1.cpu_flag} !== 2'b11) begin
      n_fail++;
      $display("FAIL mid_burst_flag: got %b%b want 11", bus0.cpu_flag, bus1.cpu_flag);
    end
    rst = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({bus0.cpu_flag, bus0.busy, bus0.missed, bus0.trig_count,
         bus1.cpu_flag, bus1.busy, bus1.missed, bus1.trig_count} !== '0) begin
      n_fail++;
      $display("FAIL mid_burst_reset: dut f/b/m/cnt=%b%b%b %0d dut_ng=%b%b%b %0d want all 0",
               bus0.cpu_flag, bus0.busy, bus0.missed, bus0.trig_count,
               bus1.cpu_flag, bus1.busy, bus1.missed, bus1.trig_count);
    end
    rst = 1'b0;
    cnt_model[0] = '0; cnt_model[1] = '0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_random();
    for (int it = 0; it < 10; it++) begin
      mode      = 2'($urandom_range(3, 0));
      pulse_len = CNT_W'($urandom_range(6, 0));
      period    = CNT_W'($urandom_range(12, 0));
      burst_cnt = CNT_W'($urandom_range(4, 0));
      wf        = ($urandom_range(3, 0) != 0);
      repeat (4) @(negedge clk);
      clear_wave();
      for (int i = 0; i < 20; i++) wave[i] = 1'($urandom_range(1, 0));
      build_model(70);
      capture(70, 1'b0);
      for (int d = 0; d < 2; d++)
        for (int i = 0; i < 70; i++) begin
          n_tests++;
          if ({cap_f[d][i], cap_b[d][i], cap_m[d][i], cap_c[d][i]} !==
              {exp_f[d][i], exp_b[d][i], exp_m[d][i], exp_c[d][i]}) begin
            n_fail++;
            $display("FAIL random it%0d m%0d l%0d p%0d b%0d wf%0d dut%0d cyc%0d f/b/m/cnt got %b%b%b %0d want %b%b%b %0d",
                     it, mode, pulse_len, period, burst_cnt, wf, d, i,
                     cap_f[d][i], cap_b[d][i], cap_m[d][i], cap_c[d][i], exp_f[d][i], exp_b[d][i], exp_m[d][i], exp_c[d][i]);
          end
        end
    end
    wf = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_wrap();
    force dut.r_trig_cnt = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.r_trig_cnt;
    cnt_model[0] = 32'hFFFF_FFFF;
    @(negedge clk);
    mode = 2'd1; pulse_len = 16'd2;
    clear_wave();
    wave[0] = 1'b1;
    build_model(8);
    capture(8, 1'b0);
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 8; i++) begin
        n_tests++;
        if ({cap_f[d][i], cap_b[d][i], cap_m[d][i], cap_c[d][i]} !==
            {exp_f[d][i], exp_b[d][i], exp_m[d][i], exp_c[d][i]}) begin
          n_fail++;
          $display("FAIL wrap dut%0d cyc%0d f/b/m/cnt got %b%b%b %0d want %b%b%b %0d", d, i,
                   cap_f[d][i], cap_b[d][i], cap_m[d][i], cap_c[d][i], exp_f[d][i], exp_b[d][i], exp_m[d][i], exp_c[d][i]);
        end
      end
  endtask

  initial begin
    rst = 1'b1; trig = 1'b0; wf = 1'b1;
    mode = '0; pulse_len = '0; period = '0; burst_cnt = '0;
    @(negedge clk);
    test_reset();
    test_level();
    test_single();
    test_back_to_back();
    test_burst();
    test_gating();
    test_reset_mid_burst();
    test_random();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
